ffe_channel_driver: RTL

//  Sample producer for the 4-tap FFE: feeds the equalizer's load_signal/Data_in input.

---
 rtl/ffe_pkg.sv | 37 +++
 rtl/ffe_ch_mac.sv | 55 +++++
 rtl/ffe_channel_driver.sv | 116 +++++++++++
 3 files changed

// File: rtl/ffe_pkg.sv
// Shared constants for the FFE test datapath: widths, channel taps, FSM states, saturation.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ffe_pkg;

  localparam int DATA_WIDTH = 12;                // Q7.4 samples and taps
  localparam int FRAC_BITS  = 4;
  localparam int NUM_TAPS   = 3;
  localparam int ACC_WIDTH  = DATA_WIDTH + 2;    // room for three full-scale terms
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  // ISI channel taps in Q7.4: 1.0, 0.5, 0.25
  localparam logic signed [DATA_WIDTH-1:0] H0 = DATA_WIDTH'(16);
  localparam logic signed [DATA_WIDTH-1:0] H1 = DATA_WIDTH'(8);
  localparam logic signed [DATA_WIDTH-1:0] H2 = DATA_WIDTH'(4);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    EMIT = 3'd4
  } state_t;

  typedef logic [1:0] tap_sel_t;

  // Clamp the wide accumulator into the sample range; never wraps.
  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
    if (a > ACC_MAX)      return ACC_MAX[DATA_WIDTH-1:0];
    else if (a < ACC_MIN) return ACC_MIN[DATA_WIDTH-1:0];
    else                  return a[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/ffe_ch_mac.sv
// Channel FIR datapath: tap select, signed multiply, floor shift, accumulate, saturate.
// Latency: one term per enabled clock; acc_sat is combinational from the accumulator.
// Backpressure: none, sequenced entirely by the driver FSM (clr/en/sel).
//
// Ports:
//   clk, rst        clock, async active-high reset
//   clr             zero the accumulator (start of a new sample)
//   en, sel         add term x[sel]*h[sel] >>> FRAC_BITS this cycle
//   x0, x1, x2      channel delay line
//   acc_sat         accumulator clamped to DATA_WIDTH
module ffe_ch_mac
  import ffe_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  tap_sel_t                     sel,
  input  logic signed [DATA_WIDTH-1:0] x0,
  input  logic signed [DATA_WIDTH-1:0] x1,
  input  logic signed [DATA_WIDTH-1:0] x2,
  output logic signed [DATA_WIDTH-1:0] acc_sat
);

  logic signed [DATA_WIDTH-1:0] x_sel;
  logic signed [DATA_WIDTH-1:0] h_sel;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [PROD_WIDTH-1:0] prod_sh;
  logic signed [ACC_WIDTH-1:0]  term;
  logic signed [ACC_WIDTH-1:0]  acc;

  always_comb begin
    x_sel = x0;
    h_sel = H0;
    case (sel)
      2'd1: begin x_sel = x1; h_sel = H1; end
      2'd2: begin x_sel = x2; h_sel = H2; end
      default: ;
    endcase
    prod    = PROD_WIDTH'(x_sel) * PROD_WIDTH'(h_sel);
    // arithmetic shift floors toward -inf, e.g. (-1*8) >>> 4 = -1
    prod_sh = prod >>> FRAC_BITS;
    // |term| <= 2048, so truncating to ACC_WIDTH keeps the value exactly
    term    = ACC_WIDTH'(prod_sh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + term;
  end

  assign acc_sat = sat(acc);

endmodule

// File: rtl/ffe_channel_driver.sv
// Symbol source -> 3-tap ISI channel -> one-clock load_signal strobe into the FFE.
// Latency: accept to load_signal rise 4 clks; one symbol per 5 clks.
// Backpressure: s_ready high only in IDLE (not on flush, not on the first clk after reset).
//
// Ports:
//   clk, rst        clock, async active-high reset
//   s_valid/s_data  upstream symbol (Q7.4), s_ready accepts it
//   flush           zero the delay line when IDLE (wins over s_valid)
//   load_signal     registered one-clk strobe; data_out holds until next strobe
//   busy            FSM not in IDLE
module ffe_channel_driver
  import ffe_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  output logic                         s_ready,
  input  logic                         flush,
  output logic                         load_signal,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         busy
);

  state_t   state, state_nxt;
  logic     started;          // low for the first edge after reset release
  logic     accept;
  logic     zero_line;
  logic     mac_clr;
  logic     mac_en;
  tap_sel_t mac_sel;

  logic signed [DATA_WIDTH-1:0] x0, x1, x2;
  logic signed [DATA_WIDTH-1:0] acc_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    accept    = 1'b0;
    zero_line = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    mac_sel   = 2'd0;
    case (state)
      IDLE: begin
        if (flush) begin
          zero_line = 1'b1;
        end else if (started) begin
          s_ready = 1'b1;
          if (s_valid) begin
            accept    = 1'b1;
            mac_clr   = 1'b1;
            state_nxt = MAC0;
          end
        end
      end
      MAC0: begin mac_en = 1'b1; mac_sel = 2'd0; state_nxt = MAC1; end
      MAC1: begin mac_en = 1'b1; mac_sel = 2'd1; state_nxt = MAC2; end
      MAC2: begin mac_en = 1'b1; mac_sel = 2'd2; state_nxt = EMIT; end
      EMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0 <= '0;
      x1 <= '0;
      x2 <= '0;
    end else if (zero_line) begin
      x0 <= '0;
      x1 <= '0;
      x2 <= '0;
    end else if (accept) begin
      x2 <= x1;
      x1 <= x0;
      x0 <= s_data;
    end
  end

  ffe_ch_mac u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (mac_clr),
    .en      (mac_en),
    .sel     (mac_sel),
    .x0      (x0),
    .x1      (x1),
    .x2      (x2),
    .acc_sat (acc_sat)
  );

  // Strobe is registered from the EMIT state so it is exactly one clock wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_signal <= 1'b0;
      data_out    <= '0;
    end else begin
      load_signal <= (state == EMIT);
      if (state == EMIT) data_out <= acc_sat;
    end
  end

  assign busy = (state != IDLE);

endmodule
